// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared command/readout enumerations and default bank sizing
package counter_bank_pkg;
    typedef enum logic [1:0] {OP_START, OP_STOP, OP_LOAD, OP_CLEAR} cmd_op_t;
    typedef enum logic {ST_IDLE, ST_HOLD} rd_state_t;
    localparam int DEF_NUM_CNT = 4;
    localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/counter_slice.sv
// counter_slice: one counter with run bit, wrap pulse and command decode
module counter_slice
    import counter_bank_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hit,
    input  cmd_op_t          op,
    input  logic [CNT_W-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);
    logic             run, run_n, inc, wrap_n;
    logic [CNT_W-1:0] count_n;

    // START leaves a running counter ticking; every other command wins over the increment
    always_comb begin
        inc     = run && !(hit && op != OP_START);
        run_n   = hit ? (op == OP_START ? 1'b1 : op == OP_LOAD ? run : 1'b0) : run;
        count_n = inc ? count + CNT_W'(1) :
                  (hit && op == OP_LOAD)  ? data :
                  (hit && op == OP_CLEAR) ? '0 : count;
        wrap_n  = inc && &count;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            run   <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            count <= count_n;
            run   <= run_n;
            wrap  <= wrap_n;
        end
    end
endmodule

// File: rtl/counter_bank_ctrl.sv
// counter_bank_ctrl: counter bank with command port and round-robin snapshot readout
module counter_bank_ctrl
    import counter_bank_pkg::*;
#(
    parameter int NUM_CNT = DEF_NUM_CNT,
    parameter int CNT_W = DEF_CNT_W,
    localparam int IDX_W = NUM_CNT > 1 ? $clog2(NUM_CNT) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [IDX_W-1:0]         cmd_idx,
    input  logic [CNT_W-1:0]         cmd_data,
    output logic [NUM_CNT*CNT_W-1:0] count,
    output logic [NUM_CNT-1:0]       wrap,
    input  logic [NUM_CNT-1:0]       rd_req,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [NUM_CNT-1:0]       rd_gnt,
    output logic [CNT_W-1:0]         rd_data
);
    logic [CNT_W-1:0] cnt [NUM_CNT];
    logic [IDX_W-1:0] last_grant, gnt_idx, sel;
    logic             found;
    rd_state_t        state, state_n;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_slice
        counter_slice #(.CNT_W(CNT_W)) u_slice (
            .clk   (clk),
            .reset (reset),
            .hit   (cmd_valid && int'(cmd_idx) == i),
            .op    (cmd_op_t'(cmd_op)),
            .data  (cmd_data),
            .count (cnt[i]),
            .wrap  (wrap[i])
        );
        assign count[i*CNT_W +: CNT_W] = cnt[i];
    end

    assign cmd_ready = reset;
    assign rd_valid  = state == ST_HOLD;
    assign rd_gnt    = rd_valid ? NUM_CNT'(1) << gnt_idx : '0;

    // Search starts one past the last served requester
    always_comb begin
        sel   = last_grant;
        found = 1'b0;
        for (int k = 1; k <= NUM_CNT; k++) begin
            if (!found && rd_req[(int'(last_grant) + k) % NUM_CNT]) begin
                found = 1'b1;
                sel   = IDX_W'((int'(last_grant) + k) % NUM_CNT);
            end
        end
        state_n = state == ST_IDLE ? (|rd_req ? ST_HOLD : ST_IDLE) : (rd_ready ? ST_IDLE : ST_HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_idx    <= '0;
            rd_data    <= '0;
            last_grant <= IDX_W'(NUM_CNT - 1);
        end else begin
            if (state == ST_IDLE && |rd_req) begin
                gnt_idx <= sel;
                rd_data <= cnt[sel];
            end
            if (state == ST_HOLD && rd_ready) last_grant <= gnt_idx;
        end
    end
endmodule

// File: tb/tb_counter_bank_ctrl.sv
// tb_counter_bank_ctrl: directed and random checks of counter_bank_ctrl against a behavioural model
module tb_counter_bank_ctrl;
    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0, reset = 1'b0;
    logic         cmd_valid = 1'b0, cmd_ready, rd_valid, rd_ready = 1'b0;
    logic [1:0]   cmd_op = 2'd0, cmd_idx = 2'd0;
    logic [W-1:0] cmd_data = '0, rd_data;
    logic [N*W-1:0] count;
    logic [N-1:0] wrap, rd_req = '0, rd_gnt;

    int mc[N];
    bit mr[N], mw[N];
    bit mhold;
    int mgnt, mlast, mdata;
    int n_vec = 0, n_err = 0;
    int wraps, wrap_at, nval, cap;
    int gq[$];

    counter_bank_ctrl dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_data(cmd_data), .count(count),
        .wrap(wrap), .rd_req(rd_req), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_gnt(rd_gnt), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mc[i] = 0;
            mr[i] = 0;
            mw[i] = 0;
        end
        mhold = 0;
        mgnt  = 0;
        mdata = 0;
        mlast = N - 1;
    endtask

    // Behaviour at one rising edge, from the inputs and model state just before it
    task automatic model_edge();
        if (!mhold && rd_req != 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (mlast + k) % N;
                if (rd_req[j]) begin
                    mgnt = j;
                    break;
                end
            end
            mdata = mc[mgnt];
            mhold = 1;
        end else if (mhold && rd_ready) begin
            mlast = mgnt;
            mhold = 0;
        end
        for (int i = 0; i < N; i++) begin
            bit hit, inc;
            hit   = cmd_valid && int'(cmd_idx) == i;
            inc   = mr[i] && !(hit && cmd_op != 2'd0);
            mw[i] = 0;
            if (hit) begin
                case (cmd_op)
                    2'd0: mr[i] = 1;
                    2'd1: mr[i] = 0;
                    2'd2: mc[i] = int'(cmd_data);
                    default: begin
                        mc[i] = 0;
                        mr[i] = 0;
                    end
                endcase
            end
            if (inc) begin
                mc[i] = (mc[i] + 1) % 256;
                mw[i] = mc[i] == 0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("count%0d", i), 32'(count[i*W +: W]), mc[i]);
            chk($sformatf("wrap%0d", i), 32'(wrap[i]), 32'(mw[i]));
        end
        chk("rd_valid", 32'(rd_valid), 32'(mhold));
        chk("rd_gnt", 32'(rd_gnt), mhold ? 32'(1) << mgnt : 32'd0);
        if (mhold) chk("rd_data", 32'(rd_data), mdata);
        chk("cmd_ready", 32'(cmd_ready), 32'(reset));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        chk("reset_rd_data", 32'(rd_data), 0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("cmd_ready_after_release", 32'(cmd_ready), 1);

        // START counter 1, watch it wrap once
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_idx = 2'd1;
        cyc();
        cmd_valid = 1'b0;
        wraps = 0; wrap_at = -1;
        for (int k = 1; k <= 300; k++) begin
            cyc();
            if (wrap[1]) begin
                wraps++;
                wrap_at = k;
                chk("wrap1_count_zero", 32'(count[15:8]), 0);
            end
        end
        chk("wrap1_pulses", wraps, 1);
        chk("wrap1_cycle", wrap_at, 256);
        chk("count0_idle", 32'(count[7:0]), 0);

        // LOAD 0xFE into running counter 2
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_idx = 2'd2;
        cyc();
        cmd_op = 2'd2; cmd_data = 8'hFE;
        cyc();
        cmd_valid = 1'b0;
        chk("load2_fe", 32'(count[23:16]), 32'hFE);
        cyc();
        chk("load2_ff", 32'(count[23:16]), 32'hFF);
        cyc();
        chk("load2_00", 32'(count[23:16]), 32'h00);
        chk("load2_wrap", 32'(wrap[2]), 1);

        // Round-robin with all requesters
        rd_req = 4'b1111; rd_ready = 1'b1;
        nval = 0;
        repeat (10) begin
            cyc();
            if (rd_valid) begin
                nval++;
                gq.push_back(int'(rd_gnt));
            end
        end
        chk("rr_valid_count", nval, 5);
        for (int k = 0; k < 5 && k < gq.size(); k++)
            chk($sformatf("rr_gnt%0d", k), gq[k], 32'(1) << (k % 4));
        rd_req = '0;
        cyc();

        // Hold snapshot of running counter 3 with rd_ready low
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_idx = 2'd3;
        rd_ready = 1'b0;
        cyc();
        cmd_valid = 1'b0;
        repeat (3) cyc();
        rd_req = 4'b1000;
        cyc();
        chk("hold_valid", 32'(rd_valid), 1);
        chk("hold_gnt", 32'(rd_gnt), 32'h8);
        cap = int'(rd_data);
        chk("hold_capture", cap, 3);
        repeat (5) begin
            cyc();
            chk("hold_stable", 32'(rd_data), cap);
        end
        rd_ready = 1'b1; rd_req = '0;
        cyc();
        chk("hold_released", 32'(rd_valid), 0);

        // Random traffic
        repeat (400) begin
            cmd_valid = 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_idx   = 2'($urandom);
            cmd_data  = ($urandom_range(3) == 0) ? 8'hFE : 8'($urandom);
            rd_req    = 4'($urandom);
            rd_ready  = 1'($urandom);
            cyc();
        end

        // Asynchronous reset while holding a snapshot
        cmd_valid = 1'b0; rd_req = 4'b0100; rd_ready = 1'b0;
        cyc();
        cyc();
        chk("pre_reset_hold", 32'(rd_valid), 1);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all();
        chk("async_rd_valid", 32'(rd_valid), 0);
        @(negedge clk);
        reset = 1'b1; rd_req = '0; rd_ready = 1'b1;
        cyc();
        cyc();
        chk("no_stale_valid", 32'(rd_valid), 0);
        rd_req = 4'b1111;
        cyc();
        chk("post_reset_gnt", 32'(rd_gnt), 1);
        rd_req = '0;
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/counter_bank_ctrl.md
COUNTER_BANK_CTRL -- requirements
Module: counter_bank_ctrl

Interface
REQ-001 Parameter NUM_CNT, 4, number of counters in the bank; index width IDX_W = clog2(NUM_CNT).
REQ-002 Parameter CNT_W, 8, counter width in bits.
REQ-003 Port clk, input, 1: clock for all state.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port cmd_valid, input, 1: command present.
REQ-006 Port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both 1.
REQ-007 Port cmd_op, input, 2: 0 START, 1 STOP, 2 LOAD, 3 CLEAR.
REQ-008 Port cmd_idx, input, IDX_W: target counter.
REQ-009 Port cmd_data, input, CNT_W: LOAD value.
REQ-010 Port count, output, NUM_CNT*CNT_W: live counter values, counter i in bits [i*CNT_W +: CNT_W].
REQ-011 Port wrap, output, NUM_CNT: per-counter wrap pulse.
REQ-012 Port rd_req, input, NUM_CNT: level read requests, one bit per requester.
REQ-013 Port rd_valid, output, 1: snapshot available.
REQ-014 Port rd_ready, input, 1: requester consumes the snapshot.
REQ-015 Port rd_gnt, output, NUM_CNT: one-hot granted requester, valid while rd_valid is 1.
REQ-016 Port rd_data, output, CNT_W: snapshot of the counter whose index equals the granted requester.

Function
REQ-017 Each counter has a run bit; while run=1 the counter increments by 1 every clk; while run=0 it holds its value.
REQ-018 Arithmetic is modulo 2^CNT_W; a running counter at 0xFF goes to 0x00.
REQ-019 wrap[i] is 1 for exactly the one cycle in which count[i] is 0x00 because of a 0xFF->0x00 increment; it is 0 after LOAD/CLEAR to 0.
REQ-020 cmd_ready is 1 in every cycle that reset is deasserted.
REQ-021 An accepted command takes effect on the next clk edge, which is a one-cycle latency.
REQ-022 START sets run; START on a running counter changes nothing.
REQ-023 STOP clears run; the value freezes at the value present at that edge.
REQ-024 LOAD writes cmd_data and leaves run unchanged; the increment is suppressed in the cycle the LOAD occurs.
REQ-025 CLEAR writes 0 and clears run.
REQ-026 A command outranks the increment of its target counter in the same cycle; all other counters increment normally.
REQ-027 cmd_idx values at or above NUM_CNT are accepted and ignored.
REQ-028 The readout FSM has two states, IDLE and HOLD.
REQ-029 In IDLE with any rd_req bit set, the FSM grants round-robin starting at (last_grant+1) mod NUM_CNT, captures the counter value, and goes to HOLD.
REQ-030 The value captured in REQ-029 is the pre-edge value: a same-cycle LOAD or increment is not visible in the snapshot.
REQ-031 In HOLD, rd_valid=1 and rd_gnt and rd_data stay stable until rd_ready=1.
REQ-032 On rd_valid and rd_ready, the FSM returns to IDLE, updates last_grant, and drops rd_valid in the next cycle.
REQ-033 Latency from rd_req seen in IDLE at edge N to rd_valid is 1 cycle; maximum throughput is one snapshot per 2 cycles.
REQ-034 Deassertion of rd_req during HOLD does not cancel the grant.
REQ-035 In IDLE, rd_valid=0 and rd_gnt=0.

Reset
REQ-036 On reset=0, immediately and asynchronously: all counts 0x00, all run bits 0, wrap 0, rd_valid 0, rd_gnt 0, rd_data 0x00, FSM IDLE, and last_grant = NUM_CNT-1 so that requester 0 has top priority.
REQ-037 Reset asserted during HOLD abandons the snapshot; after release, no rd_valid appears without a new request.
REQ-038 Counters are stopped after reset and need START to run.

Structure
REQ-039 Shared package counter_bank_pkg holds the cmd_op enumeration, the readout state enumeration, and the default NUM_CNT and CNT_W constants.
REQ-040 One sub-module, counter_slice, is instantiated NUM_CNT times and holds the count, run bit, wrap pulse, and command decode for one counter.
REQ-041 The arbiter and FSM live in the top level; there are no clock-domain crossings.

Verification
REQ-042 Reset release, START idx1, 300 cycles -> count1 wraps; wrap[1] pulses once with count1=0x00 at 256 cycles after the first increment; other counters stay at 0.
REQ-043 LOAD idx2 0xFE with counter 2 running, then 2 cycles -> count2 = 0xFE, 0xFF, 0x00; wrap[2] pulses in the 0x00 cycle.
REQ-044 rd_req=4'b1111 held, rd_ready=1 -> rd_gnt sequence 0001, 0010, 0100, 1000, 0001, with rd_valid high every other cycle.
REQ-045 rd_req[3]=1, rd_ready=0 for 5 cycles while counter 3 runs -> rd_data constant at the captured value; accepted on the 6th cycle.
REQ-046 Reset pulsed during HOLD -> rd_valid falls with no clock edge, all counts 0x00, and the next grant after reset goes to requester 0.
